// File: rtl/decode_cycle.sv
// Decode stage: register file with write-through bypass, instruction field
// decode, ID/EX pipeline register and a one-deep replay buffer that resolves
// load-use hazards by inserting a single bubble.
module decode_cycle #(
  parameter logic [31:0] NOP_INSTR = 32'h68000000,
  parameter logic [3:0]  RA_REG    = 4'd15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instruction_D,
  input  logic [31:0] pc_D,
  input  logic        isbranchtaken_E,
  input  logic        interrupt,
  input  logic        wb_en_W,
  input  logic [3:0]  rd_W,
  input  logic [31:0] result_W,
  output logic        add_stall,
  output logic [31:0] pc_E,
  output logic [31:0] op1_E,
  output logic [31:0] op2_E,
  output logic [31:0] imm_E,
  output logic [31:0] branchtarget_E,
  output logic [4:0]  opcode_E,
  output logic [3:0]  rd_E,
  output logic        isimm_E,
  output logic        iswb_E,
  output logic        isld_E,
  output logic        isst_E,
  output logic        isbeq_E,
  output logic        isbgt_E,
  output logic        isubranch_E,
  output logic        iscall_E,
  output logic        isret_E
);

  localparam logic [4:0] OP_CMP  = 5'b00101;
  localparam logic [4:0] OP_NOT  = 5'b01000;
  localparam logic [4:0] OP_MOV  = 5'b01001;
  localparam logic [4:0] OP_ASR  = 5'b01100;
  localparam logic [4:0] OP_NOP  = NOP_INSTR[31:27];
  localparam logic [4:0] OP_LD   = 5'b01110;
  localparam logic [4:0] OP_ST   = 5'b01111;
  localparam logic [4:0] OP_BEQ  = 5'b10000;
  localparam logic [4:0] OP_BGT  = 5'b10001;
  localparam logic [4:0] OP_B    = 5'b10010;
  localparam logic [4:0] OP_CALL = 5'b10011;
  localparam logic [4:0] OP_RET  = 5'b10100;

  logic [31:0] r_regs [16];
  logic        r_replay_valid;
  logic [31:0] r_replay_instr;
  logic [31:0] r_replay_pc;

  logic [31:0] w_instr;
  logic [31:0] w_pc;
  logic [4:0]  w_op;
  logic        w_i;
  logic [3:0]  w_rd;
  logic [3:0]  w_rs1;
  logic [3:0]  w_rs2;
  logic [15:0] w_imm16;
  logic [1:0]  w_mod;
  logic [26:0] w_off;
  logic [3:0]  w_addr_a;
  logic [3:0]  w_addr_b;
  logic [31:0] w_rdata_a;
  logic [31:0] w_rdata_b;
  logic [31:0] w_imm;
  logic [31:0] w_btarget;
  logic        w_iswb;
  logic [3:0]  w_rd_dec;
  logic        w_reads_a;
  logic        w_reads_b;
  logic        w_hazard;
  logic        w_flush;
  logic        w_stall;

  // A pending replay takes precedence over whatever fetch presents this cycle.
  assign w_instr = r_replay_valid ? r_replay_instr : instruction_D;
  assign w_pc    = r_replay_valid ? r_replay_pc    : pc_D;

  assign w_op    = w_instr[31:27];
  assign w_i     = w_instr[26];
  assign w_rd    = w_instr[25:22];
  assign w_rs1   = w_instr[21:18];
  assign w_rs2   = w_instr[17:14];
  assign w_imm16 = w_instr[15:0];
  assign w_mod   = w_instr[17:16];
  assign w_off   = w_instr[26:0];

  // ret reads the link register; st reads its data register on port B.
  assign w_addr_a = (w_op == OP_RET) ? RA_REG : w_rs1;
  assign w_addr_b = (w_op == OP_ST)  ? w_rd   : w_rs2;

  // Same-cycle writeback is forwarded so decode never sees a stale value.
  assign w_rdata_a = (wb_en_W && (rd_W == w_addr_a)) ? result_W : r_regs[w_addr_a];
  assign w_rdata_b = (wb_en_W && (rd_W == w_addr_b)) ? result_W : r_regs[w_addr_b];

  assign w_btarget = w_pc + {{3{w_off[26]}}, w_off, 2'b00};
  assign w_rd_dec  = (w_op == OP_CALL) ? RA_REG : w_rd;
  assign w_flush   = isbranchtaken_E | interrupt;

  // Immediate expansion; the unused modifier encoding behaves as sign-extend.
  always_comb begin
    w_imm = {{16{w_imm16[15]}}, w_imm16};
    case (w_mod)
      2'b01:   w_imm = {16'h0000, w_imm16};
      2'b10:   w_imm = {w_imm16, 16'h0000};
      default: w_imm = {{16{w_imm16[15]}}, w_imm16};
    endcase
  end

  // Writeback enable: ALU ops other than cmp, plus ld and call.
  always_comb begin
    w_iswb = 1'b0;
    if ((w_op <= OP_ASR) && (w_op != OP_CMP)) begin
      w_iswb = 1'b1;
    end else if ((w_op == OP_LD) || (w_op == OP_CALL)) begin
      w_iswb = 1'b1;
    end else begin
      w_iswb = 1'b0;
    end
  end

  // Which read ports the active instruction actually consumes.
  always_comb begin
    w_reads_a = 1'b1;
    case (w_op)
      OP_NOT, OP_MOV, OP_NOP, OP_B, OP_BEQ, OP_BGT, OP_CALL: w_reads_a = 1'b0;
      default:                                              w_reads_a = 1'b1;
    endcase
    w_reads_b = ((!w_i) && (w_op <= OP_ASR)) || (w_op == OP_ST);
  end

  // A load in EX whose destination feeds this instruction needs one bubble.
  always_comb begin
    w_hazard = 1'b0;
    if (isld_E && iswb_E) begin
      w_hazard = (w_reads_a && (w_addr_a == rd_E)) ||
                 (w_reads_b && (w_addr_b == rd_E));
    end else begin
      w_hazard = 1'b0;
    end
  end

  assign w_stall   = (!rst) && (!w_flush) && (!r_replay_valid) && w_hazard;
  assign add_stall = w_stall;

  // Register file: reset clears every entry and overrides writeback.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        r_regs[i] <= 32'h0000_0000;
      end
    end else if (wb_en_W) begin
      r_regs[rd_W] <= result_W;
    end
  end

  // Replay buffer: hold the stalled instruction for exactly one cycle.
  always_ff @(posedge clk) begin
    if (rst || w_flush) begin
      r_replay_valid <= 1'b0;
      r_replay_instr <= 32'h0000_0000;
      r_replay_pc    <= 32'h0000_0000;
    end else if (w_stall) begin
      r_replay_valid <= 1'b1;
      r_replay_instr <= instruction_D;
      r_replay_pc    <= pc_D;
    end else begin
      r_replay_valid <= 1'b0;
    end
  end

  // ID/EX register: bubble on reset, flush or stall, otherwise the decode.
  always_ff @(posedge clk) begin
    if (rst || w_flush || w_stall) begin
      pc_E           <= 32'h0000_0000;
      op1_E          <= 32'h0000_0000;
      op2_E          <= 32'h0000_0000;
      imm_E          <= 32'h0000_0000;
      branchtarget_E <= 32'h0000_0000;
      opcode_E       <= OP_NOP;
      rd_E           <= 4'd0;
      isimm_E        <= 1'b0;
      iswb_E         <= 1'b0;
      isld_E         <= 1'b0;
      isst_E         <= 1'b0;
      isbeq_E        <= 1'b0;
      isbgt_E        <= 1'b0;
      isubranch_E    <= 1'b0;
      iscall_E       <= 1'b0;
      isret_E        <= 1'b0;
    end else begin
      pc_E           <= w_pc;
      op1_E          <= w_rdata_a;
      op2_E          <= w_rdata_b;
      imm_E          <= w_imm;
      branchtarget_E <= w_btarget;
      opcode_E       <= w_op;
      rd_E           <= w_rd_dec;
      isimm_E        <= w_i;
      iswb_E         <= w_iswb;
      isld_E         <= (w_op == OP_LD);
      isst_E         <= (w_op == OP_ST);
      isbeq_E        <= (w_op == OP_BEQ);
      isbgt_E        <= (w_op == OP_BGT);
      isubranch_E    <= (w_op == OP_B) || (w_op == OP_CALL) || (w_op == OP_RET);
      iscall_E       <= (w_op == OP_CALL);
      isret_E        <= (w_op == OP_RET);
    end
  end

endmodule

// File: tb/tb_decode_cycle.sv
// Scoreboard bench for decode_cycle: the driver pushes hand-computed
// expectations, a negedge monitor pops and compares them.
module tb_decode_cycle;

  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_SUB  = 5'b00001;
  localparam logic [4:0] OP_MOV  = 5'b01001;
  localparam logic [4:0] OP_NOP  = 5'b01101;
  localparam logic [4:0] OP_LD   = 5'b01110;
  localparam logic [4:0] OP_ST   = 5'b01111;
  localparam logic [4:0] OP_B    = 5'b10010;
  localparam logic [4:0] OP_CALL = 5'b10011;
  localparam logic [4:0] OP_RET  = 5'b10100;

  logic        clk;
  logic        rst;
  logic [31:0] instruction_D;
  logic [31:0] pc_D;
  logic        isbranchtaken_E;
  logic        interrupt;
  logic        wb_en_W;
  logic [3:0]  rd_W;
  logic [31:0] result_W;
  logic        add_stall;
  logic [31:0] pc_E, op1_E, op2_E, imm_E, branchtarget_E;
  logic [4:0]  opcode_E;
  logic [3:0]  rd_E;
  logic        isimm_E, iswb_E, isld_E, isst_E, isbeq_E, isbgt_E;
  logic        isubranch_E, iscall_E, isret_E;

  decode_cycle dut (
    .clk(clk), .rst(rst), .instruction_D(instruction_D), .pc_D(pc_D),
    .isbranchtaken_E(isbranchtaken_E), .interrupt(interrupt),
    .wb_en_W(wb_en_W), .rd_W(rd_W), .result_W(result_W),
    .add_stall(add_stall), .pc_E(pc_E), .op1_E(op1_E), .op2_E(op2_E),
    .imm_E(imm_E), .branchtarget_E(branchtarget_E), .opcode_E(opcode_E),
    .rd_E(rd_E), .isimm_E(isimm_E), .iswb_E(iswb_E), .isld_E(isld_E),
    .isst_E(isst_E), .isbeq_E(isbeq_E), .isbgt_E(isbgt_E),
    .isubranch_E(isubranch_E), .iscall_E(iscall_E), .isret_E(isret_E)
  );

  // flags order: {ld, st, beq, bgt, ubranch, call, ret}
  typedef struct packed {
    int          id;
    int          due;
    logic [4:0]  op;
    logic [3:0]  rd;
    logic        isimm;
    logic        iswb;
    logic [6:0]  fl;
    logic [31:0] pc;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] imm;
    logic [31:0] bt;
    logic        ci;
    logic        cb;
  } exp_t;

  typedef struct packed {
    int   id;
    int   due;
    logic st;
  } st_t;

  exp_t eq[$];
  st_t  sq[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  initial clk = 1'b1;
  always #5 clk = ~clk;

  // Cycle counter used to time-stamp expectations.
  always @(posedge clk) cyc = cyc + 1;

  function automatic exp_t mk(input logic [4:0] op, input logic [3:0] rd,
                              input logic isimm, input logic iswb, input logic [6:0] fl,
                              input logic [31:0] pc, input logic [31:0] op1,
                              input logic [31:0] op2, input logic [31:0] imm,
                              input logic [31:0] bt, input logic ci, input logic cb);
    exp_t e;
    e.id = 0; e.due = 0; e.op = op; e.rd = rd; e.isimm = isimm; e.iswb = iswb;
    e.fl = fl; e.pc = pc; e.op1 = op1; e.op2 = op2; e.imm = imm; e.bt = bt;
    e.ci = ci; e.cb = cb;
    return e;
  endfunction

  function automatic exp_t bub();
    return mk(OP_NOP, 4'd0, 1'b0, 1'b0, 7'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b1);
  endfunction

  function automatic logic [31:0] alu_r(input logic [4:0] op, input logic [3:0] rd,
                                        input logic [3:0] rs1, input logic [3:0] rs2);
    return {op, 1'b0, rd, rs1, rs2, 14'd0};
  endfunction

  function automatic logic [31:0] alu_i(input logic [4:0] op, input logic [3:0] rd,
                                        input logic [3:0] rs1, input logic [1:0] md,
                                        input logic [15:0] imm);
    return {op, 1'b1, rd, rs1, md, imm};
  endfunction

  function automatic logic [31:0] br(input logic [4:0] op, input logic [26:0] off);
    return {op, off};
  endfunction

  task automatic step(input int id, input logic r, input logic fb, input logic fi,
                      input logic [31:0] ins, input logic [31:0] pc,
                      input logic we, input logic [3:0] wr, input logic [31:0] wd,
                      input logic es, input exp_t e);
    st_t  s;
    exp_t x;
    rst = r; isbranchtaken_E = fb; interrupt = fi;
    instruction_D = ins; pc_D = pc;
    wb_en_W = we; rd_W = wr; result_W = wd;
    s.id = id; s.due = cyc; s.st = es;
    sq.push_back(s);
    x = e; x.id = id; x.due = cyc + 1;
    eq.push_back(x);
    @(posedge clk);
    #1;
  endtask

  // Monitor: stall is checked in its own cycle, ID/EX one edge later.
  always @(negedge clk) begin
    st_t  s;
    exp_t e;
    logic ok;
    logic [6:0] fl;
    while (sq.size() > 0 && sq[0].due == cyc) begin
      s = sq.pop_front();
      n_tests++;
      if (add_stall !== s.st) begin
        n_fail++;
        $display("FAIL stall[%0d] got %b want %b", s.id, add_stall, s.st);
      end
    end
    while (eq.size() > 0 && eq[0].due == cyc) begin
      e = eq.pop_front();
      fl = {isld_E, isst_E, isbeq_E, isbgt_E, isubranch_E, iscall_E, isret_E};
      ok = (opcode_E === e.op) && (rd_E === e.rd) && (isimm_E === e.isimm) &&
           (iswb_E === e.iswb) && (fl === e.fl) && (pc_E === e.pc) &&
           (op1_E === e.op1) && (op2_E === e.op2) &&
           ((!e.ci) || (imm_E === e.imm)) && ((!e.cb) || (branchtarget_E === e.bt));
      n_tests++;
      if (!ok) begin
        n_fail++;
        $display("FAIL idex[%0d] got op=%h rd=%h i=%b wb=%b fl=%b pc=%h a=%h b=%h imm=%h bt=%h want op=%h rd=%h i=%b wb=%b fl=%b pc=%h a=%h b=%h imm=%h bt=%h",
                 e.id, opcode_E, rd_E, isimm_E, iswb_E, fl, pc_E, op1_E, op2_E, imm_E, branchtarget_E,
                 e.op, e.rd, e.isimm, e.iswb, e.fl, e.pc, e.op1, e.op2, e.imm, e.bt);
      end
    end
  end

  localparam logic [6:0] F_LD  = 7'b1000000;
  localparam logic [6:0] F_ST  = 7'b0100000;
  localparam logic [6:0] F_B   = 7'b0000100;
  localparam logic [6:0] F_CL  = 7'b0000110;
  localparam logic [6:0] F_RT  = 7'b0000101;

  initial begin
    logic [31:0] ldi, addh, subi;
    rst = 1'b1; isbranchtaken_E = 1'b0; interrupt = 1'b0;
    instruction_D = 32'd0; pc_D = 32'd0; wb_en_W = 1'b0; rd_W = 4'd0; result_W = 32'd0;
    ldi  = alu_i(OP_LD, 4'd1, 4'd2, 2'b00, 16'h0004);
    addh = alu_r(OP_ADD, 4'd3, 4'd1, 4'd4);
    subi = alu_r(OP_SUB, 4'd7, 4'd4, 4'd4);
    #1;
    // reset, with a writeback that must be ignored
    step(0, 1'b1, 1'b0, 1'b0, alu_r(OP_ADD, 4'd3, 4'd1, 4'd2), 32'h4, 1'b1, 4'd1, 32'h55, 1'b0, bub());
    step(1, 1'b1, 1'b0, 1'b0, alu_r(OP_ADD, 4'd3, 4'd1, 4'd2), 32'h4, 1'b1, 4'd1, 32'h55, 1'b0, bub());
    step(2, 1'b0, 1'b0, 1'b0, alu_r(OP_ADD, 4'd3, 4'd1, 4'd2), 32'h4, 1'b0, 4'd0, 32'h0, 1'b0,
         mk(OP_ADD, 4'd3, 1'b0, 1'b1, 7'd0, 32'h4, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0));
    // immediate modifiers
    step(3, 1'b0, 1'b0, 1'b0, alu_i(OP_MOV, 4'd1, 4'd0, 2'b00, 16'hFFFF), 32'h8, 1'b1, 4'd2, 32'h22, 1'b0,
         mk(OP_MOV, 4'd1, 1'b1, 1'b1, 7'd0, 32'h8, 32'h0, 32'h0, 32'hFFFFFFFF, 32'h0, 1'b1, 1'b0));
    step(4, 1'b0, 1'b0, 1'b0, alu_i(OP_MOV, 4'd1, 4'd0, 2'b01, 16'hFFFF), 32'hC, 1'b1, 4'd4, 32'h44, 1'b0,
         mk(OP_MOV, 4'd1, 1'b1, 1'b1, 7'd0, 32'hC, 32'h0, 32'h0, 32'h0000FFFF, 32'h0, 1'b1, 1'b0));
    step(5, 1'b0, 1'b0, 1'b0, alu_i(OP_MOV, 4'd1, 4'd0, 2'b10, 16'hFFFF), 32'h10, 1'b1, 4'd5, 32'h11111111, 1'b0,
         mk(OP_MOV, 4'd1, 1'b1, 1'b1, 7'd0, 32'h10, 32'h0, 32'h0, 32'hFFFF0000, 32'h0, 1'b1, 1'b0));
    step(6, 1'b0, 1'b0, 1'b0, alu_i(OP_MOV, 4'd1, 4'd0, 2'b11, 16'h8001), 32'h14, 1'b0, 4'd0, 32'h0, 1'b0,
         mk(OP_MOV, 4'd1, 1'b1, 1'b1, 7'd0, 32'h14, 32'h0, 32'h0, 32'hFFFF8001, 32'h0, 1'b1, 1'b0));
    // write-through bypass beats the stored value
    step(7, 1'b0, 1'b0, 1'b0, alu_r(OP_ADD, 4'd6, 4'd5, 4'd5), 32'h20, 1'b1, 4'd5, 32'hDEADBEEF, 1'b0,
         mk(OP_ADD, 4'd6, 1'b0, 1'b1, 7'd0, 32'h20, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0, 32'h0, 1'b0, 1'b0));
    step(8, 1'b0, 1'b0, 1'b0, alu_r(OP_ADD, 4'd3, 4'd2, 4'd4), 32'h24, 1'b0, 4'd0, 32'h0, 1'b0,
         mk(OP_ADD, 4'd3, 1'b0, 1'b1, 7'd0, 32'h24, 32'h22, 32'h44, 32'h0, 32'h0, 1'b0, 1'b0));
    // branches
    step(9, 1'b0, 1'b0, 1'b0, br(OP_B, 27'h7FFFFFE), 32'h100, 1'b0, 4'd0, 32'h0, 1'b0,
         mk(OP_B, 4'd15, 1'b1, 1'b0, F_B, 32'h100, 32'h0, 32'h0, 32'hFFFFFFFE, 32'hF8, 1'b1, 1'b1));
    step(10, 1'b0, 1'b0, 1'b0, br(OP_CALL, 27'd4), 32'h200, 1'b1, 4'd15, 32'hABCD0000, 1'b0,
         mk(OP_CALL, 4'd15, 1'b0, 1'b1, F_CL, 32'h200, 32'h0, 32'h0, 32'h4, 32'h210, 1'b1, 1'b1));
    step(11, 1'b0, 1'b0, 1'b0, br(OP_RET, 27'd0), 32'h300, 1'b0, 4'd0, 32'h0, 1'b0,
         mk(OP_RET, 4'd0, 1'b0, 1'b0, F_RT, 32'h300, 32'hABCD0000, 32'h0, 32'h0, 32'h300, 1'b1, 1'b1));
    // load-use on port A with replay
    step(12, 1'b0, 1'b0, 1'b0, ldi, 32'h10, 1'b0, 4'd0, 32'h0, 1'b0,
         mk(OP_LD, 4'd1, 1'b1, 1'b1, F_LD, 32'h10, 32'h22, 32'h0, 32'h4, 32'h0, 1'b1, 1'b0));
    step(13, 1'b0, 1'b0, 1'b0, addh, 32'h14, 1'b0, 4'd0, 32'h0, 1'b1, bub());
    step(14, 1'b0, 1'b0, 1'b0, subi, 32'h18, 1'b1, 4'd1, 32'h1234, 1'b0,
         mk(OP_ADD, 4'd3, 1'b0, 1'b1, 7'd0, 32'h14, 32'h1234, 32'h44, 32'h0, 32'h0, 1'b0, 1'b0));
    step(15, 1'b0, 1'b0, 1'b0, subi, 32'h18, 1'b0, 4'd0, 32'h0, 1'b0,
         mk(OP_SUB, 4'd7, 1'b0, 1'b1, 7'd0, 32'h18, 32'h44, 32'h44, 32'h0, 32'h0, 1'b0, 1'b0));
    // branch flush overrides the hazard, no replay afterwards
    step(16, 1'b0, 1'b0, 1'b0, ldi, 32'h40, 1'b0, 4'd0, 32'h0, 1'b0,
         mk(OP_LD, 4'd1, 1'b1, 1'b1, F_LD, 32'h40, 32'h22, 32'h0, 32'h4, 32'h0, 1'b1, 1'b0));
    step(17, 1'b0, 1'b1, 1'b0, addh, 32'h44, 1'b0, 4'd0, 32'h0, 1'b0, bub());
    step(18, 1'b0, 1'b0, 1'b0, subi, 32'h48, 1'b0, 4'd0, 32'h0, 1'b0,
         mk(OP_SUB, 4'd7, 1'b0, 1'b1, 7'd0, 32'h48, 32'h44, 32'h44, 32'h0, 32'h0, 1'b0, 1'b0));
    // interrupt flush
    step(19, 1'b0, 1'b0, 1'b0, ldi, 32'h50, 1'b0, 4'd0, 32'h0, 1'b0,
         mk(OP_LD, 4'd1, 1'b1, 1'b1, F_LD, 32'h50, 32'h22, 32'h0, 32'h4, 32'h0, 1'b1, 1'b0));
    step(20, 1'b0, 1'b0, 1'b1, addh, 32'h54, 1'b0, 4'd0, 32'h0, 1'b0, bub());
    step(21, 1'b0, 1'b0, 1'b0, subi, 32'h58, 1'b0, 4'd0, 32'h0, 1'b0,
         mk(OP_SUB, 4'd7, 1'b0, 1'b1, 7'd0, 32'h58, 32'h44, 32'h44, 32'h0, 32'h0, 1'b0, 1'b0));
    // load-use through the store data port
    step(22, 1'b0, 1'b0, 1'b0, ldi, 32'h60, 1'b0, 4'd0, 32'h0, 1'b0,
         mk(OP_LD, 4'd1, 1'b1, 1'b1, F_LD, 32'h60, 32'h22, 32'h0, 32'h4, 32'h0, 1'b1, 1'b0));
    step(23, 1'b0, 1'b0, 1'b0, alu_i(OP_ST, 4'd1, 4'd2, 2'b00, 16'h0000), 32'h64, 1'b0, 4'd0, 32'h0, 1'b1, bub());
    step(24, 1'b0, 1'b0, 1'b0, subi, 32'h68, 1'b0, 4'd0, 32'h0, 1'b0,
         mk(OP_ST, 4'd1, 1'b1, 1'b0, F_ST, 32'h64, 32'h22, 32'h1234, 32'h0, 32'h0, 1'b1, 1'b0));
    step(25, 1'b0, 1'b0, 1'b0, subi, 32'h68, 1'b0, 4'd0, 32'h0, 1'b0,
         mk(OP_SUB, 4'd7, 1'b0, 1'b1, 7'd0, 32'h68, 32'h44, 32'h44, 32'h0, 32'h0, 1'b0, 1'b0));
    // mov-immediate does not read the loaded register
    step(26, 1'b0, 1'b0, 1'b0, ldi, 32'h70, 1'b0, 4'd0, 32'h0, 1'b0,
         mk(OP_LD, 4'd1, 1'b1, 1'b1, F_LD, 32'h70, 32'h22, 32'h0, 32'h4, 32'h0, 1'b1, 1'b0));
    step(27, 1'b0, 1'b0, 1'b0, alu_i(OP_MOV, 4'd1, 4'd0, 2'b00, 16'h0005), 32'h74, 1'b0, 4'd0, 32'h0, 1'b0,
         mk(OP_MOV, 4'd1, 1'b1, 1'b1, 7'd0, 32'h74, 32'h0, 32'h0, 32'h5, 32'h0, 1'b1, 1'b0));
    // reset during replay discards the replayed instruction and clears regs
    step(28, 1'b0, 1'b0, 1'b0, ldi, 32'h80, 1'b0, 4'd0, 32'h0, 1'b0,
         mk(OP_LD, 4'd1, 1'b1, 1'b1, F_LD, 32'h80, 32'h22, 32'h0, 32'h4, 32'h0, 1'b1, 1'b0));
    step(29, 1'b0, 1'b0, 1'b0, addh, 32'h84, 1'b0, 4'd0, 32'h0, 1'b1, bub());
    step(30, 1'b1, 1'b0, 1'b0, subi, 32'h88, 1'b0, 4'd0, 32'h0, 1'b0, bub());
    step(31, 1'b0, 1'b0, 1'b0, subi, 32'h88, 1'b0, 4'd0, 32'h0, 1'b0,
         mk(OP_SUB, 4'd7, 1'b0, 1'b1, 7'd0, 32'h88, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0));
    // reset suppresses a stall that would otherwise fire
    step(32, 1'b0, 1'b0, 1'b0, ldi, 32'h90, 1'b0, 4'd0, 32'h0, 1'b0,
         mk(OP_LD, 4'd1, 1'b1, 1'b1, F_LD, 32'h90, 32'h0, 32'h0, 32'h4, 32'h0, 1'b1, 1'b0));
    step(33, 1'b1, 1'b0, 1'b0, addh, 32'h94, 1'b0, 4'd0, 32'h0, 1'b0, bub());
    step(34, 1'b0, 1'b0, 1'b0, 32'h68000000, 32'h94, 1'b0, 4'd0, 32'h0, 1'b0,
         mk(OP_NOP, 4'd0, 1'b0, 1'b0, 7'd0, 32'h94, 32'h0, 32'h0, 32'h0, 32'h94, 1'b1, 1'b1));
    @(negedge clk);
    #1;
    n_tests++;
    if ((sq.size() + eq.size()) != 0) begin
      n_fail++;
      $display("FAIL drain got %0d pending want 0", sq.size() + eq.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
